// File: rtl/stopwatch_button_ctrl.sv
// rtl/stopwatch_button_ctrl.sv - button conditioning, run/pause/lap FSM and lap-freeze display path
module stopwatch_button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LAP_MAX         = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [23:0] time_bcd,
  output logic        sw_start,
  output logic        sw_stop,
  output logic        sw_reset,
  output logic [23:0] disp_bcd,
  output logic        run,
  output logic        lap_active,
  output logic [2:0]  lap_count
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] LAP_SAT = 3'(LAP_MAX);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, LAP} state_e;

  // Bit 0 is the start/stop button, bit 1 the lap/reset button.
  logic [1:0]            s1_q, s2_q, db_q, db_d, db_prev_q;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  ss_evt, lr_evt;

  state_e      state_q;
  logic        sw_start_q, sw_stop_q, sw_reset_q, run_q, lap_q;
  logic [2:0]  lap_cnt_q;
  logic [23:0] lap_bcd_q, disp_q;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= {btn_lr, btn_ss};
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign ss_evt = db_q[0] & ~db_prev_q[0];
  assign lr_evt = db_q[1] & ~db_prev_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sw_start_q <= 1'b0;
      sw_stop_q  <= 1'b0;
      sw_reset_q <= 1'b0;
      run_q      <= 1'b0;
      lap_q      <= 1'b0;
      lap_cnt_q  <= '0;
      lap_bcd_q  <= '0;
      disp_q     <= '0;
    end else begin
      sw_start_q <= 1'b0;
      sw_stop_q  <= 1'b0;
      sw_reset_q <= 1'b0;
      // On the capture edge the live sample equals the captured value, so
      // the frozen display needs no special first cycle.
      disp_q     <= (state_q == LAP) ? lap_bcd_q : time_bcd;
      case (state_q)
        IDLE: begin
          if (ss_evt) begin
            sw_start_q <= 1'b1;
            run_q      <= 1'b1;
            state_q    <= RUNNING;
          end
        end
        RUNNING: begin
          if (ss_evt) begin
            sw_stop_q <= 1'b1;
            run_q     <= 1'b0;
            state_q   <= PAUSED;
          end else if (lr_evt) begin
            lap_bcd_q <= time_bcd;
            if (lap_cnt_q < LAP_SAT) lap_cnt_q <= lap_cnt_q + 3'd1;
            lap_q     <= 1'b1;
            state_q   <= LAP;
          end
        end
        LAP: begin
          if (ss_evt) begin
            sw_stop_q <= 1'b1;
            run_q     <= 1'b0;
            lap_q     <= 1'b0;
            state_q   <= PAUSED;
          end else if (lr_evt) begin
            lap_q   <= 1'b0;
            state_q <= RUNNING;
          end
        end
        PAUSED: begin
          if (ss_evt) begin
            sw_start_q <= 1'b1;
            run_q      <= 1'b1;
            state_q    <= RUNNING;
          end else if (lr_evt) begin
            sw_reset_q <= 1'b1;
            lap_cnt_q  <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_start   = sw_start_q;
  assign sw_stop    = sw_stop_q;
  assign sw_reset   = sw_reset_q;
  assign run        = run_q;
  assign lap_active = lap_q;
  assign lap_count  = lap_cnt_q;
  assign disp_bcd   = disp_q;

endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// tb/tb_stopwatch_button_ctrl.sv - scoreboard bench for stopwatch_button_ctrl
module tb_stopwatch_button_ctrl;

  localparam int DB   = 4;
  localparam int LAT  = DB + 3;
  localparam int HOLD = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_ss = 1'b0;
  logic        btn_lr = 1'b0;
  logic [23:0] time_bcd = '0;
  logic        sw_start, sw_stop, sw_reset, run, lap_active;
  logic [23:0] disp_bcd;
  logic [2:0]  lap_count;

  stopwatch_button_ctrl #(.DEBOUNCE_CYCLES(DB), .LAP_MAX(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .time_bcd   (time_bcd),
    .sw_start   (sw_start),
    .sw_stop    (sw_stop),
    .sw_reset   (sw_reset),
    .disp_bcd   (disp_bcd),
    .run        (run),
    .lap_active (lap_active),
    .lap_count  (lap_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [2:0] sw;
    logic       run;
    logic       lap;
    logic [2:0] cnt;
  } ev_t;

  ev_t q[$];

  // Reference model: 0 idle, 1 running, 2 paused, 3 lap
  int m_st = 0;
  int m_cnt = 0;

  task automatic model(input logic ss, input logic lr, input int t);
    ev_t e;
    bit  push;
    push = 1'b0;
    e.cyc = t;
    e.sw  = 3'b000;
    if (ss) begin
      push = 1'b1;
      if (m_st == 0 || m_st == 2) begin e.sw = 3'b100; m_st = 1; end
      else begin e.sw = 3'b010; m_st = 2; end
    end else if (lr) begin
      case (m_st)
        1: begin push = 1'b1; if (m_cnt < 7) m_cnt++; m_st = 3; end
        3: begin push = 1'b1; m_st = 1; end
        2: begin push = 1'b1; e.sw = 3'b001; m_cnt = 0; m_st = 0; end
        default: ;
      endcase
    end
    e.run = (m_st == 1 || m_st == 3);
    e.lap = (m_st == 3);
    e.cnt = 3'(m_cnt);
    if (push) q.push_back(e);
  endtask

  task automatic press(input logic ss, input logic lr);
    @(posedge clk);
    #1;
    model(ss, lr, cyc + LAT);
    btn_ss = ss;
    btn_lr = lr;
    repeat (HOLD) @(posedge clk);
    #1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (HOLD) @(posedge clk);
  endtask

  bit         mon_en = 1'b0;
  logic       p_run = 1'b0, p_lap = 1'b0;
  logic [2:0] p_cnt = '0;

  initial begin
    ev_t        e;
    logic [2:0] sw;
    forever begin
      @(negedge clk);
      sw = {sw_start, sw_stop, sw_reset};
      if (mon_en && (sw != 3'b000 || {run, lap_active, lap_count} != {p_run, p_lap, p_cnt})) begin
        if (q.size() == 0) begin
          chk("spurious_out", {24'd0, sw, run, lap_active, lap_count}, {24'd0, 3'b000, p_run, p_lap, p_cnt});
        end else begin
          e = q.pop_front();
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_sw", sw, e.sw);
          chk("evt_run", run, e.run);
          chk("evt_lap", lap_active, e.lap);
          chk("evt_cnt", lap_count, e.cnt);
          chk("one_hot", $countones(sw) <= 1, 1);
        end
      end
      p_run = run;
      p_lap = lap_active;
      p_cnt = lap_count;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sw", {sw_start, sw_stop, sw_reset}, 0);
    chk("rst_run", run, 0);
    chk("rst_lap", lap_active, 0);
    chk("rst_cnt", lap_count, 0);
    chk("rst_disp", disp_bcd, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // bounce shorter than the debounce window
    repeat (2) begin
      @(posedge clk); #1 btn_ss = 1'b1;
      repeat (2) @(posedge clk);
      #1 btn_ss = 1'b0;
      repeat (1) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bounce_run", run, 0);

    press(1'b1, 1'b0);

    // lap freeze
    time_bcd = 24'h000123;
    press(1'b0, 1'b1);
    @(posedge clk); #1 time_bcd = 24'h000130;
    repeat (2) @(negedge clk);
    chk("lap_hold", disp_bcd, 24'h000123);
    chk("lap_active", lap_active, 1);
    chk("lap_count1", lap_count, 1);
    press(1'b0, 1'b1);
    @(posedge clk); #1 time_bcd = 24'h000131;
    @(negedge clk);
    chk("disp_prev", disp_bcd, 24'h000130);
    @(negedge clk);
    chk("disp_track", disp_bcd, 24'h000131);
    chk("lap_release", lap_active, 0);

    // stop, clear, ignored lr in idle
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    @(negedge clk);
    chk("idle_run", run, 0);
    chk("idle_cnt", lap_count, 0);

    // simultaneous presses: ss wins
    press(1'b1, 1'b0);
    time_bcd = 24'h000200;
    press(1'b1, 1'b1);
    @(posedge clk); #1 time_bcd = 24'h000201;
    repeat (2) @(negedge clk);
    chk("simul_live", disp_bcd, 24'h000201);

    // saturation
    press(1'b1, 1'b0);
    time_bcd = 24'h012345;
    for (int i = 0; i < 18; i++) press(1'b0, 1'b1);
    @(negedge clk);
    chk("lap_sat", lap_count, 7);
    chk("sb_drained1", q.size(), 0);

    // async reset mid-cycle
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_sw", {sw_start, sw_stop, sw_reset}, 0);
    chk("arst_run", run, 0);
    chk("arst_lap", lap_active, 0);
    chk("arst_cnt", lap_count, 0);
    chk("arst_disp", disp_bcd, 0);
    m_st = 0;
    m_cnt = 0;
    btn_ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    model(1'b1, 1'b0, cyc + LAT);
    repeat (HOLD) @(posedge clk);
    #1 btn_ss = 1'b0;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    chk("held_thru_rst_run", run, 1);
    chk("sb_drained2", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
